// File: rtl/neuron_layer_sequencer.sv
// Time-multiplexed fully-connected layer: one fp32 multiplier and one fp32 adder
// are shared by every neuron, weights stream in from a synchronous RAM.

// Combinational fp32 multiplier, round-to-nearest-even, denormals flushed to zero
module spfp_multiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic               s, g, st;
  logic [47:0]        prod;
  logic [23:0]        m;
  logic [24:0]        mr;
  logic signed [9:0]  e;

  // Special cases first, then normalise the 48-bit product and round
  always_comb begin
    s    = a[31] ^ b[31];
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e    = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    m    = 24'h0;
    g    = 1'b0;
    st   = 1'b0;
    mr   = 25'h0;
    y    = {s, 31'h0};
    if ((a[30:23] == 8'hFF && a[22:0] != 23'h0) || (b[30:23] == 8'hFF && b[22:0] != 23'h0)) begin
      y = 32'h7FC00000;
    end else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      y = (a[30:23] == 8'h00 || b[30:23] == 8'h00) ? 32'h7FC00000 : {s, 8'hFF, 23'h0};
    end else if (a[30:23] != 8'h00 && b[30:23] != 8'h00) begin
      if (prod[47]) begin
        m  = prod[47:24];
        g  = prod[23];
        st = |prod[22:0];
        e  = e + 10'sd1;
      end else begin
        m  = prod[46:23];
        g  = prod[22];
        st = |prod[21:0];
      end
      mr = {1'b0, m} + {24'h0, g & (st | m[0])};
      if (mr[24]) begin
        e  = e + 10'sd1;
        mr = {1'b0, mr[24:1]};
      end
      if (e >= 10'sd255)     y = {s, 8'hFF, 23'h0};
      else if (e <= 10'sd0)  y = {s, 31'h0};
      else                   y = {s, e[7:0], mr[22:0]};
    end
  end
endmodule

// Combinational fp32 adder/subtractor, round-to-nearest-even, denormals flushed to zero
module spfp_adder_subtractor (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] y
);
  logic               sa, sb, sl, ss;
  logic [7:0]         ea, eb, el, es, diff;
  logic [26:0]        ml, ms, msh;
  logic [27:0]        sum;
  logic [24:0]        mr;
  logic signed [9:0]  e;

  // Align the smaller operand with guard/round/sticky bits, add, normalise, round
  always_comb begin
    sa   = a[31];
    sb   = b[31] ^ sub;
    ea   = a[30:23];
    eb   = b[30:23];
    sl   = sa;
    ss   = sb;
    el   = ea;
    es   = eb;
    ml   = {1'b1, a[22:0], 3'b0};
    ms   = {1'b1, b[22:0], 3'b0};
    diff = 8'h0;
    msh  = 27'h0;
    sum  = 28'h0;
    mr   = 25'h0;
    e    = 10'sd0;
    y    = 32'h0;
    if ((ea == 8'hFF && a[22:0] != 23'h0) || (eb == 8'hFF && b[22:0] != 23'h0)) begin
      y = 32'h7FC00000;
    end else if (ea == 8'hFF && eb == 8'hFF) begin
      y = (sa == sb) ? {sa, 8'hFF, 23'h0} : 32'h7FC00000;
    end else if (ea == 8'hFF) begin
      y = {sa, 8'hFF, 23'h0};
    end else if (eb == 8'hFF) begin
      y = {sb, 8'hFF, 23'h0};
    end else if (ea == 8'h00 && eb == 8'h00) begin
      y = {sa & sb, 31'h0};
    end else if (ea == 8'h00) begin
      y = {sb, b[30:0]};
    end else if (eb == 8'h00) begin
      y = a;
    end else begin
      if (a[30:0] < b[30:0]) begin
        sl = sb;
        ss = sa;
        el = eb;
        es = ea;
        ml = {1'b1, b[22:0], 3'b0};
        ms = {1'b1, a[22:0], 3'b0};
      end
      diff = el - es;
      if (diff >= 8'd27) begin
        msh = 27'h1;
      end else begin
        msh = ms >> diff;
        if ((ms & ((27'h1 << diff) - 27'h1)) != 27'h0) msh[0] = 1'b1;
      end
      sum = (sl == ss) ? ({1'b0, ml} + {1'b0, msh}) : ({1'b0, ml} - {1'b0, msh});
      e   = {2'b0, el};
      if (sum != 28'h0) begin
        if (sum[27]) begin
          sum = {1'b0, sum[27:2], sum[1] | sum[0]};
          e   = e + 10'sd1;
        end else begin
          for (int i = 0; i < 27; i++) begin
            if (!sum[26]) begin
              sum = sum << 1;
              e   = e - 10'sd1;
            end
          end
        end
        mr = {1'b0, sum[26:3]} + {24'h0, sum[2] & (sum[1] | sum[0] | sum[3])};
        if (mr[24]) begin
          e  = e + 10'sd1;
          mr = {1'b0, mr[24:1]};
        end
        if (e >= 10'sd255)     y = {sl, 8'hFF, 23'h0};
        else if (e <= 10'sd0)  y = {sl, 31'h0};
        else                   y = {sl, e[7:0], mr[22:0]};
      end
    end
  end
endmodule

module neuron_layer_sequencer #(
  parameter int N_IN    = 8,
  parameter int N_OUT   = 8,
  parameter int AW      = $clog2(N_IN * N_OUT),
  parameter int OW      = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  parameter int RELU_EN = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  output logic          w_rd_en,
  output logic [AW-1:0] w_addr,
  input  logic [31:0]   w_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [OW-1:0] out_idx,
  output logic          layer_done,
  output logic          busy
);
  localparam int EW = $clog2(N_IN);

  typedef enum logic [1:0] {LOAD, MAC, DRAIN, EMIT} state_t;

  state_t          state, state_next;
  logic [EW-1:0]   elem, elem_d;
  logic [OW-1:0]   neuron;
  logic            mac_pending;
  logic [31:0]     acc, product, acc_sum;
  logic [31:0]     in_buf [N_IN];
  logic            last_elem, last_neuron;

  assign last_elem   = (elem == EW'(N_IN - 1));
  assign last_neuron = (neuron == OW'(N_OUT - 1));

  spfp_multiplier u_mul (
    .a (in_buf[elem_d]),
    .b (w_rdata),
    .y (product)
  );

  spfp_adder_subtractor u_add (
    .a   (acc),
    .b   (product),
    .sub (1'b0),
    .y   (acc_sum)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  // Next-state logic and the handshake/strobe outputs decoded from state
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    w_rd_en    = 1'b0;
    w_addr     = '0;
    out_valid  = 1'b0;
    layer_done = 1'b0;
    busy       = 1'b1;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && last_elem) state_next = MAC;
      end
      MAC: begin
        w_rd_en = 1'b1;
        w_addr  = AW'(32'(neuron) * 32'(N_IN) + 32'(elem));
        if (last_elem) state_next = DRAIN;
      end
      DRAIN: state_next = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          layer_done = last_neuron;
          state_next = last_neuron ? LOAD : MAC;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // Input vector storage; contents are only meaningful after a full LOAD
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) in_buf[elem] <= in_data;
  end

  // Counters, serial accumulator and the registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem        <= '0;
      elem_d      <= '0;
      neuron      <= '0;
      mac_pending <= 1'b0;
      acc         <= 32'h0;
      out_data    <= 32'h0;
      out_idx     <= '0;
    end else begin
      mac_pending <= (state == MAC);
      elem_d      <= elem;
      if (mac_pending) acc <= acc_sum;
      case (state)
        LOAD: begin
          if (in_valid) begin
            if (last_elem) begin
              elem   <= '0;
              neuron <= '0;
              acc    <= 32'h0;
            end else begin
              elem <= elem + 1'b1;
            end
          end
        end
        MAC: elem <= last_elem ? '0 : elem + 1'b1;
        DRAIN: begin
          out_data <= (RELU_EN != 0 && acc_sum[31]) ? 32'h0 : acc_sum;
          out_idx  <= neuron;
        end
        EMIT: begin
          if (out_ready && !last_neuron) begin
            neuron <= neuron + 1'b1;
            elem   <= '0;
            acc    <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Bench for neuron_layer_sequencer with N_IN=4, N_OUT=2; a ReLU and a raw instance run in lockstep
module tb_neuron_layer_sequencer;
  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int AW    = 3;
  localparam int OW    = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, out_ready;
  logic [31:0]   in_data, w_rdata;
  logic          in_ready, w_rd_en, out_valid, layer_done, busy;
  logic [AW-1:0] w_addr;
  logic [31:0]   out_data;
  logic [OW-1:0] out_idx;
  logic          in_ready_raw, w_rd_en_raw, out_valid_raw, layer_done_raw, busy_raw;
  logic [AW-1:0] w_addr_raw;
  logic [31:0]   out_data_raw;
  logic [OW-1:0] out_idx_raw;

  typedef struct {
    logic [31:0] relu;
    logic [31:0] raw;
    int          idx;
  } exp_t;

  exp_t sb_q[$];
  real  xv [N_IN];
  real  wv [N_IN*N_OUT];
  real  val_set [8] = '{-2.0, -1.0, -0.5, 0.0, 0.5, 1.0, 1.5, 3.0};
  int   checks = 0;
  int   failures = 0;
  int   exp_addr = 0;
  int   rd_count = 0;
  int   ld_count = 0;

  always #5 clk = ~clk;

  neuron_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .AW(AW), .OW(OW), .RELU_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .layer_done(layer_done), .busy(busy)
  );

  neuron_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .AW(AW), .OW(OW), .RELU_EN(0)) dut_raw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_raw), .in_data(in_data),
    .w_rd_en(w_rd_en_raw), .w_addr(w_addr_raw), .w_rdata(w_rdata), .out_valid(out_valid_raw),
    .out_ready(out_ready), .out_data(out_data_raw), .out_idx(out_idx_raw),
    .layer_done(layer_done_raw), .busy(busy_raw)
  );

  // Exact real-to-fp32 conversion; only used on dyadic values that fp32 holds exactly
  function automatic logic [31:0] dbl2sp(input real r);
    logic [63:0] d;
    int          ee;
    if (r == 0.0) return 32'h0;
    d  = $realtobits(r);
    ee = int'(d[62:52]) - 1023 + 127;
    return {d[63], ee[7:0], d[51:29]};
  endfunction

  // Synchronous weight RAM: data one cycle after the read strobe
  always @(posedge clk) begin
    if (w_rd_en) w_rdata <= dbl2sp(wv[w_addr]);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Output/weight-port monitor; samples on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (w_rd_en) begin
        checkOutput("w_addr", 32'(w_addr), 32'(exp_addr));
        exp_addr = (exp_addr + 1) % (N_IN * N_OUT);
        rd_count++;
      end
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          checkOutput("out_data", out_data, sb_q[0].relu);
          checkOutput("out_idx", 32'(out_idx), 32'(sb_q[0].idx));
          checkOutput("raw_valid", 32'(out_valid_raw), 32'd1);
          checkOutput("raw_data", out_data_raw, sb_q[0].raw);
          if (out_ready) begin
            checkOutput("layer_done", 32'(layer_done), 32'(sb_q[0].idx == N_OUT - 1));
            if (layer_done) ld_count++;
            void'(sb_q.pop_front());
          end else begin
            checkOutput("hold_no_rd", 32'(w_rd_en), 32'd0);
          end
        end
      end else begin
        checkOutput("layer_done_idle", 32'(layer_done), 32'd0);
      end
    end
  end

  task automatic pushExpected();
    real  acc;
    exp_t e;
    for (int n = 0; n < N_OUT; n++) begin
      acc = 0.0;
      for (int i = 0; i < N_IN; i++) acc = acc + xv[i] * wv[n*N_IN + i];
      e.raw  = dbl2sp(acc);
      e.relu = (acc < 0.0) ? 32'h0 : e.raw;
      e.idx  = n;
      sb_q.push_back(e);
    end
  endtask

  // Feed one vector (optionally with a bubble before each beat) and check the start-up timing
  task automatic applyStimulus(input bit gappy);
    pushExpected();
    for (int i = 0; i < N_IN; i++) begin
      if (gappy) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("no_rd_in_load", 32'(w_rd_en), 32'd0);
      end
      in_valid = 1'b1;
      in_data  = dbl2sp(xv[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checkOutput("first_rd", 32'(w_rd_en), 32'd1);
    checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
    checkOutput("busy_flag", 32'(busy), 32'd1);
    repeat (N_IN) begin @(posedge clk); #1; end
    checkOutput("valid_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("valid_latency", 32'(out_valid), 32'd1);
  endtask

  task automatic waitLayerDone();
    bit seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (layer_done) seen = 1'b1;
    end
    checkOutput("layer_done_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    checkOutput("in_ready_after_done", 32'(in_ready), 32'd1);
    checkOutput("reads_per_layer", 32'(rd_count), 32'(N_IN * N_OUT));
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    rd_count = 0;
  endtask

  task automatic randomLayer();
    for (int i = 0; i < N_IN; i++) xv[i] = val_set[$urandom_range(0, 7)];
    for (int i = 0; i < N_IN*N_OUT; i++) wv[i] = val_set[$urandom_range(0, 7)];
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_w_rd_en"}, 32'(w_rd_en), 32'd0);
    checkOutput({tag, "_w_addr"}, 32'(w_addr), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_out_data"}, out_data, 32'd0);
    checkOutput({tag, "_out_idx"}, 32'(out_idx), 32'd0);
    checkOutput({tag, "_layer_done"}, 32'(layer_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    bit hit;
    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst = 1'b0;

    // T1: in=[1,2,1,2], neuron0 weights 1.0, neuron1 weights -1.0 -> 6.0 / 0 (raw -6.0)
    xv = '{1.0, 2.0, 1.0, 2.0};
    for (int i = 0; i < N_IN; i++) begin wv[i] = 1.0; wv[N_IN + i] = -1.0; end
    out_ready = 1'b1;
    applyStimulus(1'b0);
    waitLayerDone();

    // T3: same layer with backpressure for 5 cycles on neuron 0
    out_ready = 1'b0;
    applyStimulus(1'b0);
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_idx", 32'(out_idx), 32'd0);
      checkOutput("hold_data", out_data, 32'h40C00000);
    end
    out_ready = 1'b1;
    waitLayerDone();

    // T4: random values with in_valid bubbles between beats
    randomLayer();
    applyStimulus(1'b1);
    waitLayerDone();

    // T5: reset during neuron 1 MAC, then a fresh vector of 0.5 with weights 2.0
    randomLayer();
    applyStimulus(1'b0);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (w_rd_en && w_addr == AW'(N_IN + 1)) hit = 1'b1;
    end
    checkOutput("mid_mac_reached", 32'(hit), 32'd1);
    rst = 1'b1;
    #1;
    checkResetValues("mid_reset");
    sb_q.delete();
    exp_addr = 0;
    rd_count = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    xv = '{0.5, 0.5, 0.5, 0.5};
    for (int i = 0; i < N_IN*N_OUT; i++) wv[i] = 2.0;
    applyStimulus(1'b0);
    checkOutput("t5_result", out_data, 32'h40800000);
    waitLayerDone();

    // T6: two back-to-back layers, second starts the cycle after layer_done
    randomLayer();
    applyStimulus(1'b0);
    waitLayerDone();
    randomLayer();
    applyStimulus(1'b0);
    waitLayerDone();

    checkOutput("layer_count", 32'(ld_count), 32'd6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
